// File: rtl/traffic_pkg.sv
// Shared phase encoding, key indices and per-phase duration lookup for the
// intersection sequencer and anything that displays or checks its phases.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_NS_G  = 3'd0,
    PH_NS_Y  = 3'd1,
    PH_NS_LG = 3'd2,
    PH_NS_LY = 3'd3,
    PH_EW_G  = 3'd4,
    PH_EW_Y  = 3'd5,
    PH_EW_LG = 3'd6,
    PH_EW_LY = 3'd7
  } phase_t;

  localparam int unsigned KEY_NS   = 0;
  localparam int unsigned KEY_EW   = 1;
  localparam int unsigned KEY_ALL  = 2;
  localparam int unsigned KEY_STEP = 3;

  function automatic logic [7:0] phase_duration(input phase_t ph, input logic [7:0] green,
                                                input logic [7:0] left, input logic [7:0] yellow);
    case (ph)
      PH_NS_G, PH_EW_G:   return green;
      PH_NS_LG, PH_EW_LG: return left;
      default:            return yellow;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t ph);
    return phase_t'(ph + 3'd1);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_key_debounce.sv
// One push-key channel: 2-FF synchronizer followed by a stability counter;
// the accepted level only follows the raw key after DEBOUNCE_CYCLES stable cycles.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_raw,
  output logic key
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      key   <= 1'b1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (sync2 == key) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: debounced keys, 1 s prescaler, 8-phase cycle with
// per-phase countdown, override freeze/release and single-step manual advance.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned GREEN_SEC       = 25,
  parameter int unsigned LEFT_SEC        = 15,
  parameter int unsigned YELLOW_SEC      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_n,
  output logic [3:0] state,
  output logic [3:0] key,
  output logic [7:0] countdown,
  output logic       sec_tick
);

  localparam int unsigned PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [7:0] GREEN  = 8'(GREEN_SEC);
  localparam logic [7:0] LEFT   = 8'(LEFT_SEC);
  localparam logic [7:0] YELLOW = 8'(YELLOW_SEC);

  phase_t        phase, phase_nx;
  logic [7:0]    cd_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          ovr_active;
  logic          ovr_ew;
  logic          key_step_d;
  logic          override;
  logic          step_edge;

  for (genvar i = 0; i < 4; i++) begin : g_db
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_raw  (key_n[i]),
      .key      (key[i])
    );
  end

  assign override  = ~(key[KEY_NS] & key[KEY_EW] & key[KEY_ALL]);
  assign step_edge = key_step_d & ~key[KEY_STEP];
  assign sec_tick  = (presc == PRESC_MAX) && !override;
  assign state     = {1'b0, phase};

  // Priority: override hold, override release, manual step, then the second tick.
  always_comb begin
    phase_nx = phase;
    cd_nx    = countdown;
    presc_nx = presc + 1'b1;
    if (override) begin
      presc_nx = '0;
    end else if (ovr_active) begin
      phase_nx = ovr_ew ? PH_EW_G : PH_NS_G;
      cd_nx    = GREEN;
      presc_nx = '0;
    end else if (step_edge) begin
      phase_nx = next_phase(phase);
      cd_nx    = phase_duration(phase_nx, GREEN, LEFT, YELLOW);
      presc_nx = '0;
    end else if (sec_tick) begin
      presc_nx = '0;
      if (countdown > 8'd1) begin
        cd_nx = countdown - 8'd1;
      end else begin
        phase_nx = next_phase(phase);
        cd_nx    = phase_duration(phase_nx, GREEN, LEFT, YELLOW);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase      <= PH_NS_G;
      countdown  <= GREEN;
      presc      <= '0;
      ovr_active <= 1'b0;
      ovr_ew     <= 1'b0;
      key_step_d <= 1'b1;
    end else begin
      phase      <= phase_nx;
      countdown  <= cd_nx;
      presc      <= presc_nx;
      ovr_active <= override;
      key_step_d <= key[KEY_STEP];
      // Remember which override owned the intersection so release picks its direction.
      if (override) ovr_ew <= key[KEY_NS] & ~key[KEY_EW];
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: stimulus queues expected output changes,
// a monitor pops one entry each time {state,countdown,key} changes.
module tb_traffic_phase_ctrl;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_n     = 4'hF;
  logic [3:0] state;
  logic [3:0] key;
  logic [7:0] countdown;
  logic       sec_tick;

  typedef struct {
    logic [3:0] st;
    logic [7:0] cd;
    logic [3:0] k;
    int         gap;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         tick_cnt = 0;
  logic [7:0] dur[8]   = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd3, 8'd2, 8'd2, 8'd2};
  logic [3:0] m_st;
  logic [7:0] m_cd;

  logic [15:0] prev_obs;
  logic [15:0] obs;
  bit          have_prev = 1'b0;
  int          last_cyc  = 0;
  exp_t        cur;

  traffic_phase_ctrl #(
    .CLK_FREQ       (10),
    .GREEN_SEC      (3),
    .LEFT_SEC       (2),
    .YELLOW_SEC     (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (key_n),
    .state    (state),
    .key      (key),
    .countdown(countdown),
    .sec_tick (sec_tick)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) cyc = cyc + 1;

  // Monitor: every observed output change must match the next queued expectation.
  initial begin
    forever begin
      @(negedge sys_clk or negedge sys_rst_n);
      #1;
      if (sec_tick === 1'b1) tick_cnt = tick_cnt + 1;
      obs = {state, countdown, key};
      if (!have_prev || obs !== prev_obs) begin
        checks = checks + 1;
        if (q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_change: got state=%0d countdown=%0d key=%b at cycle %0d, required no change",
                   state, countdown, key, cyc);
        end else begin
          cur = q.pop_front();
          if (state !== cur.st || countdown !== cur.cd || key !== cur.k ||
              (cur.gap != 0 && (cyc - last_cyc) != cur.gap)) begin
            errors = errors + 1;
            $display("FAIL %s: got state=%0d countdown=%0d key=%b after %0d cycles, required state=%0d countdown=%0d key=%b after %0d cycles",
                     cur.name, state, countdown, key, cyc - last_cyc, cur.st, cur.cd, cur.k, cur.gap);
          end
        end
        prev_obs  = obs;
        have_prev = 1'b1;
        last_cyc  = cyc;
      end
    end
  end

  task automatic push(input logic [3:0] s, input logic [7:0] c, input logic [3:0] k,
                      input int gap, input string nm);
    exp_t e;
    e.st   = s;
    e.cd   = c;
    e.k    = k;
    e.gap  = gap;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick_ev(input int gap, input logic [3:0] k, input string nm);
    if (m_cd > 8'd1) begin
      m_cd = m_cd - 8'd1;
    end else begin
      m_st = 4'((m_st + 4'd1) % 4'd8);
      m_cd = dur[m_st[2:0]];
    end
    push(m_st, m_cd, k, gap, nm);
  endtask

  task automatic ticks(input int n, input logic [3:0] k, input string nm);
    for (int i = 0; i < n; i++) tick_ev(10, k, nm);
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic drain(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      #2;
      if (q.size() == 0) return;
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: %0d expected changes still pending after %0d cycles, required 0",
             nm, q.size(), budget);
    summary();
  endtask

  initial begin
    // Reset state and one full free-running cycle back to phase 0.
    m_st = 4'd0;
    m_cd = 8'd3;
    push(4'd0, 8'd3, 4'hF, 0, "reset_state");
    tick_ev(0, 4'hF, "free_run_first");
    ticks(17, 4'hF, "free_run");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    drain(300, "free_run");

    // Two-cycle glitch on key_n[0] must be rejected.
    tick_ev(10, 4'hF, "glitch_no_freeze");
    key_n[0] = 1'b0;
    repeat (2) @(negedge sys_clk);
    #2;
    key_n[0] = 1'b1;
    drain(50, "glitch_no_freeze");

    // N-S override held 10 cycles, release back to phase 0, then run to phase 5.
    push(4'd0, 8'd2, 4'b1110, 6, "ns_override_on");
    push(4'd0, 8'd2, 4'hF, 10, "ns_override_off");
    push(4'd0, 8'd3, 4'hF, 1, "ns_release");
    m_st = 4'd0;
    m_cd = 8'd3;
    ticks(13, 4'hF, "run_to_ph5");
    key_n[0] = 1'b0;
    repeat (10) @(negedge sys_clk);
    #2;
    key_n[0] = 1'b1;
    drain(300, "run_to_ph5");

    // E-W override at phase 5 countdown 1: freeze, no ticks, release to phase 4.
    tick_cnt = 0;
    push(4'd5, 8'd1, 4'b1101, 6, "ew_override_on");
    push(4'd5, 8'd1, 4'hF, 20, "ew_override_off");
    push(4'd4, 8'd3, 4'hF, 1, "ew_release");
    m_st = 4'd4;
    m_cd = 8'd3;
    key_n[1] = 1'b0;
    repeat (20) @(negedge sys_clk);
    #2;
    key_n[1] = 1'b1;
    drain(100, "ew_release");
    checks = checks + 1;
    if (tick_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL override_no_tick: got %0d sec_tick pulses, required 0", tick_cnt);
    end
    ticks(14, 4'hF, "run_to_ph2");
    drain(200, "run_to_ph2");

    // Manual step in phase 2, key held 50 cycles advances only once.
    push(4'd2, 8'd2, 4'b0111, 6, "step_key_down");
    push(4'd3, 8'd2, 4'b0111, 1, "step_advance");
    m_st = 4'd3;
    m_cd = 8'd2;
    ticks(4, 4'b0111, "step_held_no_repeat");
    push(4'd4, 8'd1, 4'hF, 9, "step_key_up");
    tick_ev(1, 4'hF, "step_release_tick");
    ticks(3, 4'hF, "run_to_ph6");
    key_n[3] = 1'b0;
    repeat (50) @(negedge sys_clk);
    #2;
    key_n[3] = 1'b1;
    drain(200, "run_to_ph6");

    // Step edge lands on the tick edge at phase 6 countdown 1: single step to 7.
    push(4'd6, 8'd1, 4'b0111, 9, "coinc_key_down");
    push(4'd7, 8'd2, 4'b0111, 1, "coinc_single_step");
    push(4'd7, 8'd2, 4'hF, 6, "coinc_key_up");
    m_st = 4'd7;
    m_cd = 8'd2;
    tick_ev(4, 4'hF, "coinc_tick");
    ticks(8, 4'hF, "run_to_ph3");
    repeat (3) @(negedge sys_clk);
    #2;
    key_n[3] = 1'b0;
    repeat (7) @(negedge sys_clk);
    #2;
    key_n[3] = 1'b1;
    drain(200, "run_to_ph3");

    // Async reset mid phase 3 while key_n[0] is mid-debounce.
    push(4'd0, 8'd3, 4'hF, 3, "async_reset");
    push(4'd0, 8'd3, 4'b1110, 9, "post_reset_debounce");
    key_n[0] = 1'b0;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    drain(50, "post_reset_debounce");
    push(4'd0, 8'd3, 4'hF, 8, "override_clear");
    push(4'd0, 8'd2, 4'hF, 11, "first_tick_after_release");
    repeat (2) @(negedge sys_clk);
    #2;
    key_n[0] = 1'b1;
    drain(50, "first_tick_after_release");

    repeat (5) @(negedge sys_clk);
    summary();
  end

endmodule
